// File: rtl/kan_pkg.sv
// kan_pkg: dataset/epoch defaults, streamer FSM states and the record type.
package kan_pkg;
  localparam int DEF_N_FEATURES = 6;
  localparam int DEF_N_T_RECORDS = 8192;
  localparam int DEF_N_V_RECORDS = 2048;
  localparam int DEF_N_EPOCHS = 32;
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;
  typedef struct packed {
    logic [DEF_N_FEATURES-1:0][31:0] features;
    logic signed [31:0] target;
  } kan_record_t;
endpackage

// File: rtl/kan_index_counter.sv
// kan_index_counter: nested record/epoch counter with wrap, epoch-end and final-record flags.
module kan_index_counter import kan_pkg::*; #(
  parameter int N_T = DEF_N_T_RECORDS,
  parameter int N_V = DEF_N_V_RECORDS,
  parameter int N_EPOCHS = DEF_N_EPOCHS,
  parameter bit VAL_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        adv,
  output logic [15:0] epoch,
  output logic        is_val,
  output logic        last_all,
  output logic        epoch_end,
  output logic        restart
);
  logic [15:0] rec;
  logic last_rec, last_epoch;
  always_comb begin
    last_rec = rec == (is_val ? 16'(N_V - 1) : 16'(N_T - 1));
    last_epoch = epoch == 16'(N_EPOCHS - 1);
    epoch_end = last_rec && !is_val;
    restart = epoch_end && !last_epoch;
    last_all = last_rec && (is_val || (last_epoch && !VAL_EN));
  end
  // the validation pass runs as one extra "epoch" numbered N_EPOCHS
  always_ff @(posedge clk)
    if (rst || clr) {rec, epoch, is_val} <= '0;
    else if (adv) begin
      rec <= last_rec ? '0 : rec + 16'd1;
      epoch <= epoch_end ? epoch + 16'd1 : epoch;
      is_val <= is_val || (VAL_EN && epoch_end && last_epoch);
    end
endmodule

// File: rtl/kan_record_streamer.sv
// kan_record_streamer: streams feature/target records for KAN training epochs.
// Define KAN_STREAMER_VALIDATION_EN to append one validation pass after training.
module kan_record_streamer import kan_pkg::*; #(
  parameter int N_FEATURES = DEF_N_FEATURES,
  parameter int N_T_RECORDS = DEF_N_T_RECORDS,
  parameter int N_V_RECORDS = DEF_N_V_RECORDS,
  parameter int N_EPOCHS = DEF_N_EPOCHS
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  input  logic               start,
  input  logic               abort,
  output logic               feat_rd_en,
  output logic [15:0]        feat_addr,
  input  logic signed [31:0] feat_rdata,
  output logic               tgt_rd_en,
  output logic [13:0]        tgt_addr,
  input  logic signed [31:0] tgt_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_features [N_FEATURES],
  output logic signed [31:0] out_target,
  output logic               out_is_val,
  output logic [15:0]        out_epoch,
  output logic               epoch_done,
  output logic               busy,
  output logic               done
);
`ifdef KAN_STREAMER_VALIDATION_EN
  localparam bit VAL_EN = 1'b1;
`else
  localparam bit VAL_EN = 1'b0;
`endif
  localparam int JW = N_FEATURES > 1 ? $clog2(N_FEATURES) : 1;
  localparam int CW = $clog2(N_FEATURES + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [JW-1:0] fj, cap_j;
  logic cap_v, cap_t, idle_start, hs;
  logic [15:0] base, next_base, c_epoch;
  logic [13:0] tgt_base, next_tgt;
  logic c_is_val, c_last_all, c_epoch_end, c_restart;
  // records are contiguous, so the next base is +N_FEATURES except at an epoch wrap
  always_comb begin
    idle_start = start && (state == IDLE || state == DONE);
    hs = state == PRESENT && out_valid && out_ready;
    next_base = c_restart ? '0 : base + 16'(N_FEATURES);
    next_tgt = c_restart ? '0 : tgt_base + 14'd1;
  end
  assign busy = state == FETCH || state == PRESENT;
  assign done = state == DONE;
  kan_index_counter #(
    .N_T(N_T_RECORDS), .N_V(N_V_RECORDS), .N_EPOCHS(N_EPOCHS), .VAL_EN(VAL_EN)
  ) u_idx (
    .clk(CLK100MHZ), .rst(!CPU_RESETN), .clr(abort || idle_start), .adv(hs),
    .epoch(c_epoch), .is_val(c_is_val), .last_all(c_last_all),
    .epoch_end(c_epoch_end), .restart(c_restart)
  );
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN || abort) begin
      state <= IDLE;
      {cnt, fj, cap_j, cap_v, cap_t, base, tgt_base} <= '0;
      {feat_rd_en, tgt_rd_en, feat_addr, tgt_addr} <= '0;
      {out_valid, out_target, out_is_val, out_epoch, epoch_done} <= '0;
      for (int i = 0; i < N_FEATURES; i++) out_features[i] <= '0;
    end else begin
      feat_rd_en <= 1'b0;
      tgt_rd_en <= 1'b0;
      epoch_done <= 1'b0;
      cap_v <= feat_rd_en;
      cap_t <= tgt_rd_en;
      cap_j <= fj;
      case (state)
        IDLE, DONE: if (start) begin
          state <= FETCH;
          cnt <= '0;
          base <= '0;
          tgt_base <= '0;
        end
        FETCH: begin
          if (cnt < CW'(N_FEATURES)) begin
            feat_rd_en <= 1'b1;
            feat_addr <= base + 16'(cnt);
            fj <= JW'(cnt);
            tgt_rd_en <= cnt == '0;
            cnt <= cnt + CW'(1);
          end
          if (cnt == '0) tgt_addr <= tgt_base;
          if (cap_t) out_target <= tgt_rdata;
          if (cap_v) out_features[cap_j] <= feat_rdata;
          if (cap_v && cap_j == JW'(N_FEATURES - 1)) begin
            state <= PRESENT;
            out_valid <= 1'b1;
            out_is_val <= VAL_EN && c_is_val;
            out_epoch <= c_epoch;
          end
        end
        PRESENT: if (out_ready) begin
          out_valid <= 1'b0;
          epoch_done <= c_epoch_end;
          state <= c_last_all ? DONE : FETCH;
          // the handshake edge already issues word 0 of the next record
          if (!c_last_all) begin
            base <= next_base;
            tgt_base <= next_tgt;
            feat_rd_en <= 1'b1;
            feat_addr <= next_base;
            fj <= '0;
            tgt_rd_en <= 1'b1;
            tgt_addr <= next_tgt;
            cnt <= CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
